sram_client: RTL and testbench
==============================

# sram_client

Client-side controller for the SRAM subsystem offer/receive/send protocol. It accepts single operations (power-on, deep-sleep, write, read) from an upstream valid/ready port and drives the subsystem's `offer` and `receive` inputs. It tracks the subsystem's `current_state`, captures read data from `send`, and returns one response per request. It sits between the host-side control logic and the SRAM subsystem state machine, one instance per subsystem.

## Interface
- `DATA_W`, default 16: width of `receive`/`send` and request/response data.
- `TIMEOUT`, default 64: WAIT-state cycle limit. Used only when the timeout is compiled in. Must be ≥ 2.

- `CLK`  in  1  clock, posedge.
- `RESETN`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid` is also high.
- `req_op`  in  2  operation: 0 POWER_ON, 1 DEEP_SLEEP, 2 WRITE, 3 READ.
- `req_data`  in  DATA_W  write data. Ignored for other operations.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  response consumed.
- `resp_data`  out  DATA_W  read data. 0 for non-read operations and for errors.
- `resp_err`  out  1  operation timed out.
- `offer`  out  4  command to the subsystem.
- `receive`  out  DATA_W  data to the subsystem.
- `send`  in  DATA_W  data from the subsystem.
- `current_state`  in  2  subsystem state.

## Operation
- Offer codes: 0 IDLE, 1 POWER_ON, 2 WRITE, 3 READ, 4 DEEP_SLEEP.
- Subsystem states: 0 BOOT, 1 OFF, 2 READ_RESP, 3 ON.
- Client FSM states: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- **IDLE:** `req_ready` = 1 only when `current_state` ∈ {OFF, ON}. On accept, register the operation and data, then go to ISSUE.
- **ISSUE (exactly 1 cycle):** drive `offer` with the operation's code and `receive` with the registered data. Go to WAIT and clear the wait counter.
- **WAIT:**
  - `offer` = 0. `receive` holds its last value.
  - The done check is ignored in the first WAIT cycle, so a pre-existing state cannot match.
  - From the second WAIT cycle onward, the done conditions are:
    - POWER_ON: `current_state` == ON.
    - DEEP_SLEEP: `current_state` == OFF.
    - WRITE: `current_state` == ON.
    - READ: `current_state` == READ_RESP, which goes to CAPTURE.
  - Non-read done goes to RESP with `resp_data` = 0.
- **CAPTURE (1 cycle):** load `resp_data` from `send`, then go to RESP.
- **RESP:** `resp_valid` = 1. `resp_data` and `resp_err` are stable until `resp_ready`. When `resp_ready` is high, go to IDLE.
- No request is accepted while RESP is pending. `req_ready` is 0 in every state except IDLE.
- Reset values: FSM IDLE, `offer` = 0, `receive` = 0, `resp_valid` = 0, `resp_data` = 0, `resp_err` = 0.
- Reset asserted mid-operation aborts the operation. No response is produced.

## Timing
- All outputs are registered.
- `req_ready` is combinational from the FSM state and `current_state`.
- `offer` is non-zero for exactly one cycle per request.
- With a subsystem that changes state one cycle after latching `offer`:
  - Non-read operation: `resp_valid` rises 4 cycles after the accept edge.
  - READ: `resp_valid` rises 5 cycles after the accept edge.
- `resp_valid` and `resp_ready` both high ends the response. IDLE is entered on the next edge, and a new accept is possible that cycle.

## Configuration
- `SRAM_CLIENT_TIMEOUT_EN` defined:
  - A counter in WAIT increments every cycle.
  - When it reaches `TIMEOUT` before the done condition, go to RESP with `resp_err` = 1 and `resp_data` = 0.
  - If the done condition and the timeout occur in the same cycle, done wins.
- `SRAM_CLIENT_TIMEOUT_EN` undefined:
  - No counter; WAIT can last indefinitely.
  - `resp_err` is tied to 0.

## Structure
- Shared package `sram_pkg` holds:
  - the offer-code constants;
  - the subsystem-state constants;
  - the `req_op` enum;
  - the client FSM state typedef.
- Sub-module `sram_client_timer` holds the wait counter, with clear/enable inputs and an expired output. It is instantiated only under `SRAM_CLIENT_TIMEOUT_EN`.

## Test plan
- `current_state` = OFF; POWER_ON request. Behavioural server moves to ON. Required: `offer` = 1 for one cycle, then `resp_valid` with `resp_data` = 0 and `resp_err` = 0, 4 cycles after accept.
- In ON: WRITE with `req_data` = 0xBEEF. Required: `receive` = 0xBEEF and `offer` = 2 in the ISSUE cycle. Response `resp_err` = 0.
- In ON: READ. Server enters READ_RESP and latches `send` = 0x1234. Required: `resp_data` = 0x1234, 5 cycles after accept.
- `current_state` = BOOT with `req_valid` = 1. Required: `req_ready` = 0 until the state becomes OFF. Hold `resp_ready` = 0 for 3 cycles. Required: response stable, no new accept.
- With `SRAM_CLIENT_TIMEOUT_EN` and `TIMEOUT` = 8: the server never reaches ON after POWER_ON. Required: `resp_err` = 1 and `resp_data` = 0 after 8 WAIT cycles.
- Deassert `RESETN` during WAIT of a READ. Required: next edge gives `offer` = 0 and `resp_valid` = 0, FSM in IDLE, and no stale response after reset is released.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM subsystem client: offer codes, subsystem
// state encodings, the request operation enum and the client FSM states.
package sram_pkg;

    // Command codes presented on the subsystem's offer input
    localparam logic [3:0] OFFER_IDLE       = 4'd0;
    localparam logic [3:0] OFFER_POWER_ON   = 4'd1;
    localparam logic [3:0] OFFER_WRITE      = 4'd2;
    localparam logic [3:0] OFFER_READ       = 4'd3;
    localparam logic [3:0] OFFER_DEEP_SLEEP = 4'd4;

    // Subsystem state as reported on current_state
    localparam logic [1:0] SS_BOOT      = 2'd0;
    localparam logic [1:0] SS_OFF       = 2'd1;
    localparam logic [1:0] SS_READ_RESP = 2'd2;
    localparam logic [1:0] SS_ON        = 2'd3;

    typedef enum logic [1:0] {
        OP_POWER_ON   = 2'd0,
        OP_DEEP_SLEEP = 2'd1,
        OP_WRITE      = 2'd2,
        OP_READ       = 2'd3
    } req_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } client_state_e;

    // Request operation to the command code sent to the subsystem
    function automatic logic [3:0] op_to_offer(input req_op_e op);
        logic [3:0] code;
        case (op)
            OP_POWER_ON:   code = OFFER_POWER_ON;
            OP_DEEP_SLEEP: code = OFFER_DEEP_SLEEP;
            OP_WRITE:      code = OFFER_WRITE;
            OP_READ:       code = OFFER_READ;
            default:       code = OFFER_IDLE;
        endcase
        return code;
    endfunction

    // Subsystem state that marks completion of each operation
    function automatic logic op_done(input req_op_e op, input logic [1:0] cs);
        logic done;
        case (op)
            OP_POWER_ON:   done = (cs == SS_ON);
            OP_DEEP_SLEEP: done = (cs == SS_OFF);
            OP_WRITE:      done = (cs == SS_ON);
            OP_READ:       done = (cs == SS_READ_RESP);
            default:       done = 1'b0;
        endcase
        return done;
    endfunction

endpackage

// File: rtl/sram_client_timer.sv
// WAIT-state cycle counter for the SRAM client. Counts up while enabled and
// flags expiry during the TIMEOUT-th enabled cycle after a clear.
module sram_client_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; hold at the last value so the counter never wraps
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/sram_client.sv
// Client controller for the SRAM subsystem offer/receive/send protocol.
// Takes one operation at a time from a valid/ready port, issues it to the
// subsystem as a single-cycle offer, waits for the matching subsystem state
// and returns one response.
// Optional WAIT timeout: define SRAM_CLIENT_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a request while subsystem is OFF or ON
// ISSUE   | offer code and receive data on the bus for one cycle
// WAIT    | offer back to 0, waiting for the completion state
// CAPTURE | read completed, sampling send into resp_data
// RESP    | response held until resp_ready
module sram_client
    import sram_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [3:0]        offer,
    output logic [DATA_W-1:0] receive,
    input  logic [DATA_W-1:0] send,
    input  logic [1:0]        current_state
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("sram_client: TIMEOUT must be at least 2");
    end

    client_state_e     r_state;
    req_op_e           r_op;
    logic [3:0]        r_offer;
    logic [DATA_W-1:0] r_receive;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_armed;

    logic w_req_ready;
    logic w_done;
    logic w_expired;

    // A stale subsystem state must not complete the op, so the first WAIT
    // cycle never arms the done check.
    assign w_req_ready = (r_state == ST_IDLE) &&
                         ((current_state == SS_OFF) || (current_state == SS_ON));
    assign w_done      = r_armed && op_done(r_op, current_state);

`ifdef SRAM_CLIENT_TIMEOUT_EN
    logic w_timer_clear;
    logic w_timer_en;
    logic r_resp_err;

    assign w_timer_clear = (r_state == ST_ISSUE);
    assign w_timer_en    = (r_state == ST_WAIT);

    sram_client_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expired(w_expired)
    );

    // Error flag: set when WAIT expires without completion, cleared on consume
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_resp_err <= 1'b0;
        end else if ((r_state == ST_WAIT) && !w_done && w_expired) begin
            r_resp_err <= 1'b1;
        end else if ((r_state == ST_RESP) && resp_ready) begin
            r_resp_err <= 1'b0;
        end
    end

    assign resp_err = r_resp_err;
`else
    assign w_expired = 1'b0;
    assign resp_err  = 1'b0;
`endif

    // Client FSM with registered bus and response outputs
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_POWER_ON;
            r_offer      <= OFFER_IDLE;
            r_receive    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_armed      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && w_req_ready) begin
                        r_op      <= req_op_e'(req_op);
                        r_offer   <= op_to_offer(req_op_e'(req_op));
                        r_receive <= req_data;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_offer <= OFFER_IDLE;
                    r_armed <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_armed <= 1'b1;
                    if (w_done) begin
                        if (r_op == OP_READ) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= '0;
                            r_state      <= ST_RESP;
                        end
                    end else if (w_expired) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= '0;
                        r_state      <= ST_RESP;
                    end
                end
                ST_CAPTURE: begin
                    r_resp_data  <= send;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_data  <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_offer      <= OFFER_IDLE;
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign offer      = r_offer;
    assign receive    = r_receive;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_sram_client.sv
// Self-checking bench for sram_client: a behavioural SRAM subsystem server,
// a transaction-level model of expected responses and latencies, directed
// protocol cases and a randomized operation sequence.
module tb_sram_client;

    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          CLK = 1'b0;
    logic          RESETN;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic [3:0]    offer;
    logic [DW-1:0] receive;
    logic [DW-1:0] send;
    logic [1:0]    cs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    sram_client #(
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_data     (req_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .offer        (offer),
        .receive      (receive),
        .send         (send),
        .current_state(cs)
    );

    // Behavioural subsystem: latches offer/receive, acts on them one cycle later
    logic          srv_boot   = 1'b1;
    logic          srv_enable = 1'b1;
    logic [3:0]    lat_offer  = 4'd0;
    logic [DW-1:0] lat_recv   = '0;
    logic [DW-1:0] srv_mem    = 16'h1234;
    logic [DW-1:0] srv_send   = '0;
    logic [1:0]    srv_cs     = 2'd0;

    assign cs   = srv_cs;
    assign send = srv_send;

    always @(posedge CLK) begin
        lat_offer <= srv_enable ? offer : 4'd0;
        lat_recv  <= receive;
        if (srv_boot) begin
            srv_cs <= 2'd0;
        end else if (srv_cs == 2'd0) begin
            srv_cs <= 2'd1;
        end else if (srv_cs == 2'd2) begin
            srv_cs <= 2'd3;
        end else begin
            case (lat_offer)
                4'd1: srv_cs <= 2'd3;
                4'd2: begin srv_mem <= lat_recv; srv_cs <= 2'd3; end
                4'd3: begin srv_send <= srv_mem; srv_cs <= 2'd2; end
                4'd4: srv_cs <= 2'd1;
                default: ;
            endcase
        end
    end

    // Reference model state: subsystem powered or not, and stored word
    bit            m_on  = 1'b0;
    logic [DW-1:0] m_mem = 16'h1234;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_code(input logic [1:0] op);
        case (op)
            2'd0: return 4'd1;
            2'd1: return 4'd4;
            2'd2: return 4'd2;
            default: return 4'd3;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One request/response. Latency counts the ISSUE cycle as cycle 1.
    task automatic run_op(input logic [1:0] op, input logic [DW-1:0] data,
                          input int hold, input bit exp_err);
        bit            got;
        bit            seen;
        int            cyc;
        int            pulses;
        int            exp_cyc;
        logic [DW-1:0] exp_data;
        exp_data = (!exp_err && op == 2'd3) ? m_mem : '0;
        exp_cyc  = exp_err ? (TMO + 2) : ((op == 2'd3) ? 5 : 4);

        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (req_ready) got = 1'b1;
            else tick();
        end
        chk("accept", 32'(got), 32'd1);
        if (!got) begin
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        chk("issue_offer", 32'(offer), 32'(exp_code(op)));
        chk("issue_receive", 32'(receive), 32'(data));

        cyc = 1; pulses = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (offer != 4'd0) pulses++;
            if (resp_valid) seen = 1'b1;
        end
        chk("resp_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc), 32'(exp_cyc));
        chk("extra_offer", 32'(pulses), 32'd0);
        chk("resp_data", 32'(resp_data), 32'(exp_data));
        chk("resp_err", 32'(resp_err), 32'(exp_err));

        // Keep a new request pending while the response is stalled
        req_valid = (hold > 0);
        req_op    = 2'd0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", 32'(resp_data), 32'(exp_data));
            chk("hold_err", 32'(resp_err), 32'(exp_err));
            chk("hold_no_accept", 32'(req_ready), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("resp_done", 32'(resp_valid), 32'd0);

        if (!exp_err) begin
            case (op)
                2'd0: m_on = 1'b1;
                2'd1: m_on = 1'b0;
                2'd2: m_mem = data;
                default: ;
            endcase
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [1:0]    op;
        logic [DW-1:0] d;
        RESETN     = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_data   = '0;
        resp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_offer", 32'(offer), 32'd0);
        chk("rst_receive", 32'(receive), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        RESETN = 1'b1;

        // Subsystem in BOOT: request must wait
        req_valid = 1'b1;
        req_op    = 2'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("boot_not_ready", 32'(req_ready), 32'd0);
        end
        srv_boot = 1'b0;
        run_op(2'd0, 16'h0, 3, 1'b0);

        // Directed: read initial word, write, read back, sleep
        run_op(2'd3, 16'h0, 0, 1'b0);
        run_op(2'd2, 16'hBEEF, 1, 1'b0);
        run_op(2'd3, 16'h0, 2, 1'b0);
        run_op(2'd1, 16'h0, 0, 1'b0);

        // Subsystem ignores the power-on
        srv_enable = 1'b0;
`ifdef SRAM_CLIENT_TIMEOUT_EN
        run_op(2'd0, 16'h0, 1, 1'b1);
`else
        begin
            bit got;
            req_valid = 1'b1;
            req_op    = 2'd0;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (req_ready) got = 1'b1;
                else tick();
            end
            chk("hang_accept", 32'(got), 32'd1);
            tick();
            req_valid = 1'b0;
            for (int i = 0; i < 30; i++) tick();
            chk("hang_no_resp", 32'(resp_valid), 32'd0);
            chk("hang_no_err", 32'(resp_err), 32'd0);
            RESETN = 1'b0;
            repeat (2) tick();
            RESETN = 1'b1;
        end
`endif
        srv_enable = 1'b1;
        tick();

        // Randomized sequence against the model
        for (int n = 0; n < 30; n++) begin
            op = m_on ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
            d  = DW'($urandom);
            run_op(op, d, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset during WAIT of a read
        if (!m_on) run_op(2'd0, 16'h0, 0, 1'b0);
        req_valid = 1'b1;
        req_op    = 2'd3;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (req_ready) got = 1'b1;
                else tick();
            end
            chk("rst_rd_accept", 32'(got), 32'd1);
        end
        tick();
        req_valid = 1'b0;
        tick();
        RESETN = 1'b0;
        tick();
        chk("abort_offer", 32'(offer), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        RESETN = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (resp_valid) stale++;
            end
            chk("abort_no_stale", 32'(stale), 32'd0);
        end
        chk("abort_idle_ready", 32'(req_ready), 32'd1);
        run_op(2'd3, 16'h0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
